// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for a single-port, byte-write, synchronous-read data RAM.
// Turns byte-addressed core requests into word-addressed RAM accesses.
// Returns one registered response per request.
// Optional build macro MEM_LSU_MISALIGN_TRAP_EN:
//   - misaligned half/word accesses and size 3 are trapped with rsp_err.
//   - the RAM is never touched for a trapped access.
module mem_lsu #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // WAIT counts down from RD_LATENCY-1 to 0; the final count is the capture cycle.
  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

  state_t                  state_q;
  logic                    req_ready_q, rsp_valid_q, rsp_err_q, mem_en_q;
  logic [31:0]             rsp_rdata_q, mem_din_q;
  logic [3:0]              mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    is_we_q, uns_q;
  logic [1:0]              size_q, off_q, cnt_q;

  logic [3:0]  lane_mask;
  logic [31:0] wdata_rep;
  logic        misalign;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Byte-lane enables and replicated store data from the incoming request.
  always_comb begin
    lane_mask = 4'b1111;
    wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Alignment trap decision; constant 0 when the trap feature is built out.
  always_comb begin
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    misalign = (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
               (req_size == 2'd3);
`else
    misalign = 1'b0;
`endif
  end

  // Lane select and sign/zero extension of the RAM read word.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = mem_dout[7:0];
      2'd1:    byte_sel = mem_dout[15:8];
      2'd2:    byte_sel = mem_dout[23:16];
      default: byte_sel = mem_dout[31:24];
    endcase
    half_sel = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_dout;
    endcase
  end

  // Request FSM; every output is a register, and pulses default low each cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      is_we_q     <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            is_we_q     <= req_we;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            off_q       <= req_addr[1:0];
            if (misalign) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q    <= S_ISSUE;
              mem_en_q   <= 1'b1;
              mem_addr_q <= req_addr[ADDR_WIDTH+1:2];
              if (req_we) begin
                mem_we_q  <= lane_mask;
                mem_din_q <= wdata_rep;
              end
            end
          end
        end
        S_ISSUE: begin
          if (is_we_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_ext;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a behavioural byte-write RAM (RD_LATENCY = 3).
module tb_mem_lsu;
  localparam int AW  = 12;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // RAM model: byte writes, read data valid LAT cycles after the en edge, junk otherwise.
  logic [31:0] ram   [16];
  logic [31:0] rpipe [LAT];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_din[8*b +: 8];
      rpipe[0] <= ram[mem_addr[3:0]];
    end else begin
      rpipe[0] <= 32'h5A5A_5A5A;
    end
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_dout = rpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One request from a negedge; checks the issue cycle, latency, data and stray enables.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [13:0] a, input logic [31:0] wd,
                        input logic [3:0] xwe, input logic [31:0] xdin, input logic [31:0] xrd);
    int n, stray;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_en"},   {31'b0, mem_en}, 32'd1);
    chk({tag, "_addr"}, {20'b0, mem_addr}, {20'b0, a[13:2]});
    chk({tag, "_we"},   {28'b0, mem_we}, {28'b0, xwe});
    if (we) chk({tag, "_din"}, mem_din, xdin);
    chk({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
    n = 1; stray = 0;
    while (!rsp_valid && n < 20) begin
      if (n > 1 && mem_en) stray++;
      @(negedge clk); n++;
    end
    if (mem_en) stray++;
    chk({tag, "_lat"},   n, we ? 32'd2 : 32'(2 + LAT));
    chk({tag, "_stray"}, stray, 32'd0);
    chk({tag, "_rd"},    rsp_rdata, xrd);
    chk({tag, "_err"},   {31'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy [8];
    logic rv  [8];
    logic en  [8];
    int n, bad;
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_en",    {31'b0, mem_en}, 32'd0);
    chk("rst_we",    {28'b0, mem_we}, 32'd0);
    chk("rst_rsp",   {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr",  {20'b0, mem_addr}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("start_ready", {31'b0, req_ready}, 32'd1);

    // Stores: word, byte lane 3, upper half, then restore the reference word.
    do_req("st_w",  1, 2'd2, 0, 14'h010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
    do_req("st_b",  1, 2'd0, 0, 14'h013, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0);
    do_req("st_h",  1, 2'd1, 0, 14'h012, 32'h00001234, 4'b1100, 32'h12341234, 32'h0);
    do_req("ld_mix", 0, 2'd2, 0, 14'h010, 32'h0, 4'b0000, 32'h0, 32'h1234BEEF);
    do_req("st_w2", 1, 2'd2, 0, 14'h010, 32'h80FF1234, 4'b1111, 32'h80FF1234, 32'h0);

    // Loads from 0x80FF1234.
    do_req("ld_bs3", 0, 2'd0, 0, 14'h013, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80);
    do_req("ld_bu3", 0, 2'd0, 1, 14'h013, 32'h0, 4'b0000, 32'h0, 32'h00000080);
    do_req("ld_bs1", 0, 2'd0, 0, 14'h011, 32'h0, 4'b0000, 32'h0, 32'h00000012);
    do_req("ld_bs2", 0, 2'd0, 0, 14'h012, 32'h0, 4'b0000, 32'h0, 32'hFFFFFFFF);
    do_req("ld_hs2", 0, 2'd1, 0, 14'h012, 32'h0, 4'b0000, 32'h0, 32'hFFFF80FF);
    do_req("ld_hu2", 0, 2'd1, 1, 14'h012, 32'h0, 4'b0000, 32'h0, 32'h000080FF);
    do_req("ld_hs0", 0, 2'd1, 0, 14'h010, 32'h0, 4'b0000, 32'h0, 32'h00001234);
    do_req("ld_w",   0, 2'd2, 0, 14'h010, 32'h0, 4'b0000, 32'h0, 32'h80FF1234);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    // Misaligned word load traps in T+1 without touching the RAM.
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 14'h012;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("trap_rsp",   {31'b0, rsp_valid}, 32'd1);
    chk("trap_err",   {31'b0, rsp_err}, 32'd1);
    chk("trap_rdata", rsp_rdata, 32'd0);
    chk("trap_en",    {31'b0, mem_en}, 32'd0);
    @(negedge clk);
    chk("trap_en2",   {31'b0, mem_en}, 32'd0);
`else
    // Without trapping: half ignores addr[0], size 3 behaves as word.
    do_req("ld_hs1", 0, 2'd1, 0, 14'h011, 32'h0, 4'b0000, 32'h0, 32'h00001234);
    do_req("st_s3",  1, 2'd3, 0, 14'h014, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0);
    do_req("ld_s3",  0, 2'd2, 0, 14'h016, 32'h0, 4'b0000, 32'h0, 32'hCAFEF00D);
`endif

    // Back-to-back loads with req_valid held high.
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 14'h010;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rdy[k] = req_ready; rv[k] = rsp_valid; en[k] = mem_en;
      if (k == 6) begin @(posedge clk); #1 req_valid = 1'b0; end
    end
    chk("b2b_rdy1", {31'b0, rdy[1]}, 32'd0);
    chk("b2b_rdy5", {31'b0, rdy[5]}, 32'd0);
    chk("b2b_rv4",  {31'b0, rv[4]}, 32'd0);
    chk("b2b_rv5",  {31'b0, rv[5]}, 32'd1);
    chk("b2b_rdy6", {31'b0, rdy[6]}, 32'd1);
    chk("b2b_en1",  {31'b0, en[1]}, 32'd1);
    chk("b2b_en7",  {31'b0, en[7]}, 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("b2b_lat2", n, 32'(LAT + 1));
    chk("b2b_rd2",  rsp_rdata, 32'h80FF1234);

    // Reset in the middle of WAIT.
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 14'h010;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mrst_en",    {31'b0, mem_en}, 32'd0);
    chk("mrst_rsp",   {31'b0, rsp_valid}, 32'd0);
    chk("mrst_ready", {31'b0, req_ready}, 32'd0);
    bad = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid || req_ready || mem_en) bad++; end
    rstn = 1'b1;
    @(negedge clk);
    if (rsp_valid) bad++;
    chk("mrst_quiet", bad, 32'd0);
    chk("mrst_ready1", {31'b0, req_ready}, 32'd1);
    do_req("ld_post", 0, 2'd0, 1, 14'h012, 32'h0, 4'b0000, 32'h0, 32'h000000FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator for the single-port byte-write data RAM (en / we[3:0] / addr / din / dout, synchronous read).
- Converts core byte-address requests (byte/half/word, signed/unsigned) into word-addressed RAM accesses with byte-lane write enables and replicated write data.
- Extracts and sign- or zero-extends read data, and returns one response per request.
- Sits between the core execute/memory stage and the data RAM.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width; byte address is ADDR_WIDTH+2 bits.
- RD_LATENCY, 1, RAM read latency in cycles from the en edge to valid dout; legal range 1..4.

Ports:
- clk  input  1  clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  input  1  load zero-extend when 1, sign-extend when 0
- req_addr  input  ADDR_WIDTH+2  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  single-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores
- rsp_err  output  1  access fault (feature only, else tied 0)
- mem_en  output  1  RAM enable
- mem_we  output  4  RAM byte write enables
- mem_addr  output  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]
- mem_din  output  32  RAM write data
- mem_dout  input  32  RAM read data

Behaviour:
- Reset (async, rstn low): state IDLE; req_ready, rsp_valid, rsp_err, mem_en = 0; mem_we = 0; mem_addr, mem_din, rsp_rdata = 0. All outputs are registered.
- Startup: req_ready rises in the first cycle after rstn deasserts.
- States: IDLE -> ISSUE -> (WAIT if load) -> RESP -> IDLE.
- IDLE: req_ready = 1. On req_valid & req_ready (cycle T), latch the request.
  - Go to ISSUE.
  - Drop req_ready in T+1.
  - Latch size, unsigned flag and addr[1:0].
- ISSUE (T+1): mem_en = 1, mem_addr driven.
  - Store: mem_we = lane mask, mem_din = replicated data; next state RESP.
  - Load: mem_we = 0; next state WAIT.
- Lane mask:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word or reserved: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- WAIT: mem_en = 0, mem_we = 0. A counter runs RD_LATENCY cycles. On the last WAIT cycle, capture mem_dout, select the lane by addr[1:0] or addr[1], extend to 32 bits, then go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle; next state IDLE, req_ready = 1 the following cycle.
- Response timing: a store responds in T+2; a load responds in T+2+RD_LATENCY. No response backpressure.
- Idle outputs: mem_en and mem_we are 0 in every state except ISSUE.
- Reset mid-operation: immediately abort, drop the pending response, and cancel any issued write that has not yet been clocked.

Optional Feature:
- Macro: MEM_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request (half with addr[0] = 1, word with addr[1:0] != 0, or size 3) skips ISSUE and WAIT.
  - RESP occurs in T+1 with rsp_err = 1 and rsp_rdata = 0; mem_en stays 0.
- Undefined:
  - rsp_err is tied 0.
  - Half ignores addr[0]; word ignores addr[1:0]; size 3 is treated as word.

Test Plan:
- Store word 0xDEADBEEF at 0x010 -> T+1: mem_en = 1, mem_addr = 4, mem_we = 4'b1111, mem_din = 0xDEADBEEF; T+2: rsp_valid = 1, rsp_rdata = 0.
- Store byte 0xA5 at 0x013 -> mem_we = 4'b1000, mem_din = 0xA5A5A5A5; store half 0x1234 at 0x012 -> mem_we = 4'b1100, mem_din = 0x12341234.
- RAM word 0x80FF1234 at 0x010; signed byte load at 0x013 -> rsp_rdata = 0xFFFFFF80 in T+3; unsigned -> 0x00000080.
- Same word: signed half at 0x012 -> 0xFFFF80FF; at 0x010 -> 0x00001234; word load -> 0x80FF1234.
- RD_LATENCY = 3, req_valid held high for two loads -> first rsp_valid at T+5, req_ready low T+1..T+5, second accepted at T+6.
- rstn low during WAIT -> mem_en = 0, no rsp_valid, req_ready = 0 until 1 cycle after release.
- With the macro defined, word load at 0x012 -> rsp_valid and rsp_err = 1 at T+1, mem_en never asserted.
